// File: rtl/counter_run_ctrl_if.sv
//============================================================================
// Module      : counter_run_ctrl_if
// Description : Bundles the button, tick and counter-control signals of
//               counter_run_ctrl.
//               master : drives buttons and ticks, observes the controls
//               slave  : the controller itself
// Signals     : btn_run, btn_step, btn_freq   raw buttons, active-high
//               tick_05Hz/1Hz/2Hz/10Hz        one-cycle rate ticks
//               enable                        count-enable pulse
//               freq_sel[1:0]                 current rate selection
//               state[1:0]                    FSM state code
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface counter_run_ctrl_if;
    logic       btn_run;
    logic       btn_step;
    logic       btn_freq;
    logic       tick_05Hz;
    logic       tick_1Hz;
    logic       tick_2Hz;
    logic       tick_10Hz;
    logic       enable;
    logic [1:0] freq_sel;
    logic [1:0] state;

    modport master (
        output btn_run, btn_step, btn_freq,
        output tick_05Hz, tick_1Hz, tick_2Hz, tick_10Hz,
        input  enable, freq_sel, state
    );

    modport slave (
        input  btn_run, btn_step, btn_freq,
        input  tick_05Hz, tick_1Hz, tick_2Hz, tick_10Hz,
        output enable, freq_sel, state
    );
endinterface

`default_nettype wire

// File: rtl/counter_run_ctrl.sv
//============================================================================
// Module      : counter_run_ctrl
// Description : Run/pause/single-step controller for a BCD counter. Three
//               raw buttons are synchronised, debounced and edge-detected;
//               the resulting presses drive an IDLE/RUN/PAUSE/STEP FSM and
//               a rate selector that picks one of four tick inputs.
// Ports       : clk    system clock, rising edge active
//               reset  synchronous active-high reset
//               ctrl   counter_run_ctrl_if.slave (buttons, ticks,
//                      enable, freq_sel, state)
// Parameters  : DB_CYCLES  consecutive samples needed to accept a level
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module counter_run_ctrl #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    counter_run_ctrl_if.slave    ctrl
);

    localparam int c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_STEP  = 2'b11;

    localparam int c_BTN_RUN  = 0;
    localparam int c_BTN_STEP = 1;
    localparam int c_BTN_FREQ = 2;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_freq_sel;
    logic [1:0] w_freq_next;
    logic       r_enable;
    logic       w_enable_next;
    logic       w_tick_sel;

    assign w_btn_raw = {ctrl.btn_freq, ctrl.btn_step, ctrl.btn_run};

    // Per-button conditioning: 2-flop synchroniser, then a debouncer whose
    // counter measures how long the sample has disagreed with the accepted
    // level, then a rising-edge detector on the accepted level.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_d;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end

        assign w_press[gi] = r_level & ~r_level_d;
    end

    // Tick chosen by the current (pre-update) rate selection, so a tick
    // coincident with a freq press still uses the old rate.
    always_comb begin
        w_tick_sel = 1'b0;
        case (r_freq_sel)
            2'b00:   w_tick_sel = ctrl.tick_05Hz;
            2'b01:   w_tick_sel = ctrl.tick_1Hz;
            2'b10:   w_tick_sel = ctrl.tick_2Hz;
            default: w_tick_sel = ctrl.tick_10Hz;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_freq_sel <= 2'b01;
            r_enable   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_freq_sel <= w_freq_next;
            r_enable   <= w_enable_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_freq_next   = r_freq_sel;
        w_enable_next = 1'b0;

        if (w_press[c_BTN_FREQ]) begin
            w_freq_next = r_freq_sel + 2'd1;
        end

        // Enable is judged against the current state, so a tick in the
        // cycle a run press leaves RUN still counts.
        if (((r_state == c_RUN) && w_tick_sel) || (r_state == c_STEP)) begin
            w_enable_next = 1'b1;
        end

        case (r_state)
            c_IDLE: begin
                if (w_press[c_BTN_RUN]) w_state_next = c_RUN;
            end
            c_RUN: begin
                if (w_press[c_BTN_RUN]) w_state_next = c_PAUSE;
            end
            c_PAUSE: begin
                // Run has priority over a simultaneous step press.
                if (w_press[c_BTN_RUN])       w_state_next = c_RUN;
                else if (w_press[c_BTN_STEP]) w_state_next = c_STEP;
            end
            c_STEP: begin
                w_state_next = c_PAUSE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    assign ctrl.enable   = r_enable;
    assign ctrl.freq_sel = r_freq_sel;
    assign ctrl.state    = r_state;

endmodule

`default_nettype wire
